// File: rtl/slow_multiplier_unsigned_if.sv
// -----------------------------------------------------------------------------
// slow_multiplier_unsigned_if
//   Request/response bundle for the iterative multiply-accumulate block.
//   master : requester, drives the operands and in_valid, receives the result.
//   slave  : the multiplier, drives in_ready, out_product and out_valid.
//
//   in_multiplicand  operand A (e.g. divider quotient)
//   in_multiplier    operand B (e.g. divider divisor)
//   in_addend        operand C (e.g. divider remainder)
//   in_valid         request, sampled when in_valid && in_ready
//   in_ready         block can accept a request this cycle
//   out_product      A*B+C, held until the next result
//   out_valid        one-cycle pulse, out_product valid
// -----------------------------------------------------------------------------
interface slow_multiplier_unsigned_if #(
    parameter int MULTIPLICAND_BITS = 5,
    parameter int MULTIPLIER_BITS   = 4
);
    localparam int PRODUCT_BITS = MULTIPLICAND_BITS + MULTIPLIER_BITS;

    logic [MULTIPLICAND_BITS-1:0] in_multiplicand;
    logic [MULTIPLIER_BITS-1:0]   in_multiplier;
    logic [MULTIPLIER_BITS-1:0]   in_addend;
    logic                         in_valid;
    logic                         in_ready;
    logic [PRODUCT_BITS-1:0]      out_product;
    logic                         out_valid;

    modport master (
        output in_multiplicand, in_multiplier, in_addend, in_valid,
        input  in_ready, out_product, out_valid
    );

    modport slave (
        input  in_multiplicand, in_multiplier, in_addend, in_valid,
        output in_ready, out_product, out_valid
    );
endinterface

// File: rtl/slow_multiplier_unsigned.sv
// -----------------------------------------------------------------------------
// slow_multiplier_unsigned
//   Iterative shift-add unsigned multiply-accumulate:
//     out_product = in_multiplicand * in_multiplier + in_addend
//   One multiplicand bit is consumed per cycle. Feeding it the quotient,
//   divisor and remainder of the slow unsigned divider rebuilds the dividend.
//
//   Ports:
//     clk  - clock, all state changes on the rising edge
//     rst  - synchronous active-high reset
//     bus  - slow_multiplier_unsigned_if.slave (operands, handshake, result)
//
//   Optional build macro:
//     SLOW_MULTIPLIER_EARLY_EXIT_EN - finish as soon as the remaining
//     multiplicand bits are all zero (busy cycles = max(1, bitlen(A)))
//     instead of always running MULTIPLICAND_BITS iterations. The product
//     is the same either way; only latency changes.
// -----------------------------------------------------------------------------
module slow_multiplier_unsigned #(
    parameter int MULTIPLICAND_BITS = 5,
    parameter int MULTIPLIER_BITS   = 4
) (
    input logic                     clk,
    input logic                     rst,
    slow_multiplier_unsigned_if.slave bus
);
    localparam int PRODUCT_BITS = MULTIPLICAND_BITS + MULTIPLIER_BITS;
    localparam int COUNTER_BITS = $clog2(MULTIPLICAND_BITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       state;
    logic [PRODUCT_BITS-1:0]      acc;
    logic [PRODUCT_BITS-1:0]      mplier;
    logic [MULTIPLICAND_BITS-1:0] mcand;
    logic [COUNTER_BITS-1:0]      counter;
    logic [PRODUCT_BITS-1:0]      product_q;
    logic                         out_valid_q;

    logic [PRODUCT_BITS-1:0]      acc_step;
    logic [MULTIPLICAND_BITS-1:0] mcand_shift;
    logic                         last_step;

    // One shift-add step. acc never overflows PRODUCT_BITS because
    // (2^A-1)(2^B-1) + (2^B-1) < 2^(A+B).
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        acc_step    = acc;
        mcand_shift = mcand >> 1;
        if (mcand[0]) begin
            acc_step = acc + mplier;
        end
`ifdef SLOW_MULTIPLIER_EARLY_EXIT_EN
        // Remaining multiplicand bits are all zero: no further adds possible.
        last_step = (mcand_shift == '0);
`else
        last_step = (counter == COUNTER_BITS'(1));
`endif
    end

    // Ready depends on state only, so a requester never sees a comb loop.
    assign bus.in_ready    = (state == IDLE) || (state == DONE);
    assign bus.out_product = product_q;
    assign bus.out_valid   = out_valid_q;

    // NOTE: all state is written with non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            mplier      <= '0;
            mcand       <= '0;
            counter     <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.in_valid) begin
                        acc     <= PRODUCT_BITS'(bus.in_addend);
                        mplier  <= PRODUCT_BITS'(bus.in_multiplier);
                        mcand   <= bus.in_multiplicand;
                        counter <= COUNTER_BITS'(MULTIPLICAND_BITS);
                        state   <= BUSY;
                    end else begin
                        state   <= IDLE;
                    end
                end
                BUSY: begin
                    acc     <= acc_step;
                    mcand   <= mcand_shift;
                    mplier  <= mplier << 1;
                    counter <= counter - COUNTER_BITS'(1);
                    if (last_step) begin
                        // Result includes this cycle's add; pulse lands in DONE.
                        product_q   <= acc_step;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_slow_multiplier_unsigned.sv
module tb_slow_multiplier_unsigned;
    localparam int MB = 5;
    localparam int BB = 4;
    localparam int N  = MB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    slow_multiplier_unsigned_if #(.MULTIPLICAND_BITS(MB), .MULTIPLIER_BITS(BB)) bus ();

    slow_multiplier_unsigned #(.MULTIPLICAND_BITS(MB), .MULTIPLIER_BITS(BB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int a;
        int b;
        int c;
        int exp_product;
        int exp_busy_full;
        int exp_busy_early;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference latency from the operand alone.
    function automatic int exp_busy(input int a);
`ifdef SLOW_MULTIPLIER_EARLY_EXIT_EN
        int len = 0;
        for (int i = 0; i < MB; i++) if ((a >> i) != 0) len = i + 1;
        return (len == 0) ? 1 : len;
`else
        return N;
`endif
    endfunction

    // Present one request; returns after the accepting edge.
    task automatic start_op(input int a, input int b, input int c);
        bus.in_multiplicand = MB'(a);
        bus.in_multiplier   = BB'(b);
        bus.in_addend       = BB'(c);
        bus.in_valid        = 1'b1;
        tick();
        bus.in_valid        = 1'b0;
    endtask

    // Count edges until out_valid; in_ready must stay low meanwhile.
    task automatic wait_done(input string name, output int cycles);
        bit ready_in_busy = 0;
        cycles = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            cycles = k;
            if (bus.out_valid) break;
            if (bus.in_ready) ready_in_busy = 1;
        end
        check({name, " out_valid seen"}, bus.out_valid, 1);
        check({name, " in_ready low in busy"}, ready_in_busy, 0);
    endtask

    initial begin
        int cyc;
        int a, b, c, q, d, r, dividend;

        bus.in_multiplicand = '0;
        bus.in_multiplier   = '0;
        bus.in_addend       = '0;
        bus.in_valid        = 1'b0;

        vecs[0] = '{13,  7,  3,  94, 5, 4};
        vecs[1] = '{31, 15, 14, 479, 5, 5};
        vecs[2] = '{ 0,  9,  5,   5, 5, 1};
        vecs[3] = '{ 4,  3,  0,  12, 5, 3};
        vecs[4] = '{ 1, 15, 15,  30, 5, 1};
        vecs[5] = '{16,  1,  0,  16, 5, 5};

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_product", bus.out_product, 0);
        check("reset in_ready", bus.in_ready, 1);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            check("table in_ready before", bus.in_ready, 1);
            start_op(vecs[i].a, vecs[i].b, vecs[i].c);
            wait_done("table", cyc);
            check("table product", bus.out_product, vecs[i].exp_product);
`ifdef SLOW_MULTIPLIER_EARLY_EXIT_EN
            check("table busy cycles", cyc, vecs[i].exp_busy_early);
`else
            check("table busy cycles", cyc, vecs[i].exp_busy_full);
`endif
            tick();
            check("table single pulse", bus.out_valid, 0);
            check("table product hold", bus.out_product, vecs[i].exp_product);
        end

        // Back-to-back: second request accepted in DONE of the first
        start_op(13, 7, 3);
        wait_done("b2b first", cyc);
        check("b2b first product", bus.out_product, 94);
        check("b2b ready in DONE", bus.in_ready, 1);
        start_op(2, 2, 1);
        check("b2b pulse ends", bus.out_valid, 0);
        check("b2b accepted", bus.in_ready, 0);
        check("b2b hold first", bus.out_product, 94);
        wait_done("b2b second", cyc);
        check("b2b second busy", cyc, exp_busy(2));
        check("b2b second product", bus.out_product, 5);
        tick();

        // Reset on the third busy cycle with in_valid high
        start_op(31, 15, 14);
        tick(); tick();
        check("abort still busy", bus.in_ready, 0);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("abort in_ready", bus.in_ready, 1);
        check("abort out_valid", bus.out_valid, 0);
        check("abort out_product", bus.out_product, 0);
        begin
            bit pulsed = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (bus.out_valid) pulsed = 1;
            end
            check("abort no pulse", pulsed, 0);
            check("abort idle ready", bus.in_ready, 1);
        end

        // Random full-range operands against plain arithmetic
        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range(0, (1 << MB) - 1));
            b = int'($urandom_range(0, (1 << BB) - 1));
            c = int'($urandom_range(0, (1 << BB) - 1));
            start_op(a, b, c);
            wait_done("rand", cyc);
            check("rand product", bus.out_product, a * b + c);
            check("rand busy", cyc, exp_busy(a));
            // Half the time chain straight from DONE, otherwise let it idle.
            if ($urandom_range(0, 1) == 0) begin
                tick();
                check("rand idle pulse", bus.out_valid, 0);
            end
        end

        // Divider round-trip: q*d + r rebuilds the dividend
        for (int i = 0; i < 1000; i++) begin
            dividend = int'($urandom_range(0, (1 << MB) - 1));
            d        = int'($urandom_range(1, (1 << BB) - 1));
            q        = dividend / d;
            r        = dividend % d;
            start_op(q, d, r);
            wait_done("divrt", cyc);
            check("divrt product", bus.out_product, dividend);
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/slow_multiplier_unsigned.md
Name: slow_multiplier_unsigned

Overview:
- Iterative shift-add unsigned multiply-accumulate: out_product = in_multiplicand * in_multiplier + in_addend.
- One multiplicand bit per cycle.
- Inverse companion of the slow unsigned divider: feeding it quotient, divisor and remainder reconstructs the dividend.
- Used for divider self-check and for low-area multiply paths.

Parameters:
- MULTIPLICAND_BITS, 5, width of in_multiplicand; equals the iteration count N.
- MULTIPLIER_BITS, 4, width of in_multiplier and in_addend.
- PRODUCT_BITS (localparam), MULTIPLICAND_BITS+MULTIPLIER_BITS, width of out_product.
- COUNTER_BITS (localparam), $clog2(MULTIPLICAND_BITS+1), width of the iteration counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_multiplicand  input  MULTIPLICAND_BITS  operand A (e.g. quotient).
- in_multiplier  input  MULTIPLIER_BITS  operand B (e.g. divisor).
- in_addend  input  MULTIPLIER_BITS  operand C (e.g. remainder).
- in_valid  input  1  request; operands sampled when in_valid && in_ready.
- in_ready  output  1  block can accept a request this cycle.
- out_product  output  PRODUCT_BITS  result A*B+C.
- out_valid  output  1  one-cycle pulse, out_product valid.

Behaviour:
- Reset: synchronous active-high reset (rst), sampled on the rising edge of clk.
  - Drives state to IDLE, out_valid=0, out_product=0, counter=0, internal registers=0.
  - Reset wins over all other events, including mid-BUSY (result discarded, no out_valid) and a coincident in_valid.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE || state==DONE); combinational from state only; low throughout BUSY.
- in_valid while in_ready is low is ignored (no queuing).
- Accept (in_valid && in_ready at edge E0):
  - acc <= zero-extended in_addend.
  - mcand <= in_multiplicand.
  - mplier <= zero-extended in_multiplier.
  - counter <= N; state <= BUSY.
- BUSY, each cycle:
  - If mcand[0]: acc <= acc + mplier (PRODUCT_BITS wide; never overflows, since max (2^A-1)(2^B-1)+2^B-1 < 2^(A+B)).
  - mcand <= mcand >> 1; mplier <= mplier << 1; counter <= counter-1.
  - When counter==1: state <= DONE and out_product <= final acc value, including this cycle's add.
- DONE:
  - out_valid=1 for exactly this cycle.
  - Next state: BUSY if a new request is accepted this cycle, else IDLE.
- Latency: out_valid high in the cycle after edge E0+N, i.e. N+1 cycles after acceptance. Max throughput is one result per N+1 cycles.
- out_product holds its value from DONE until the next DONE (or reset). It is not cleared on accept.
- out_valid is 0 in all states except DONE.
- Zero operands need no special case: A=0 or B=0 gives out_product = C after the full N iterations.

Optional Feature:
- Macro: SLOW_MULTIPLIER_EARLY_EXIT_EN.
- Defined: in BUSY, if (mcand>>1)==0 after the current cycle's step (remaining multiplicand bits all zero), transition to DONE immediately with the current acc, regardless of counter.
  - Busy cycles = max(1, bit-length of A); A=0 and A=1 both take 1 busy cycle.
- Undefined: always exactly N busy cycles.
- out_product is identical either way; only latency differs.

Test Plan:
- Defaults, A=13, B=7, C=3 accepted at E0 -> out_valid single pulse after edge E0+5, out_product=94; in_ready low during the 5 BUSY cycles.
- Max operands A=31, B=15, C=14 -> out_product=479 (9 bits, no overflow).
- A=0, B=9, C=5 -> out_product=5 after 5 BUSY cycles (1 with SLOW_MULTIPLIER_EARLY_EXIT_EN); A=4, B=3, C=0 -> 12 after 5 (3 with macro) BUSY cycles.
- Back-to-back: second request (A=2, B=2, C=1) presented during DONE of the first -> accepted that cycle; first result pulses; second result 5 is valid N+1 cycles later; out_product holds the first value in between.
- rst asserted on the third BUSY cycle with in_valid high -> next cycle state IDLE, in_ready=1, out_valid never pulses for the aborted op, out_product=0.
- Divider round-trip: random (dividend, nonzero divisor) through the slow divider, then quotient/divisor/remainder into this block -> out_product equals the original zero-extended dividend for 1000 vectors.
